// File: rtl/karatsuba_pp_gen_pkg.sv
// Shared types and constants for the Karatsuba partial-product generator.
package karatsuba_pp_gen_pkg;

  localparam int KPP_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_HI  = 3'd1,
    MUL_LO  = 3'd2,
    MUL_MID = 3'd3,
    OUT     = 3'd4
  } kpp_state_t;

endpackage

// File: rtl/karatsuba_pp_gen_mul.sv
// Combinational unsigned N x N multiplier with a full 2N-bit product.
// With N = W/2+1 the product is W+2 bits, wide enough for (aH+aL)*(bH+bL).
module kpp_mul #(
  parameter int N = 17
) (
  input  logic [N-1:0]   i_x,
  input  logic [N-1:0]   i_y,
  output logic [2*N-1:0] o_p
);

  assign o_p = i_x * i_y;

endmodule

// File: rtl/karatsuba_pp_gen.sv
// One-level Karatsuba split: produces g1 = k1<<W, g2 = (k3-k2-k1)<<W/2 and
// g3 = k2 so that g1+g2+g3 = a*b. A single multiplier is reused over three
// cycles; the terms are handed to a downstream adder with valid/ready.
module karatsuba_pp_gen
  import karatsuba_pp_gen_pkg::*;
#(
  parameter int W = KPP_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] g1,
  output logic [2*W-1:0] g2,
  output logic [2*W-1:0] g3
);

  localparam int H = W / 2;   // half-operand width
  localparam int S = H + 1;   // half-sum width (carry kept)
  localparam int P = W + 2;   // product width

  kpp_state_t r_state, w_next;

  logic [W-1:0] r_a, r_b;
  logic [P-1:0] r_k1, r_k2, r_k3;

  logic [H-1:0] w_ah, w_al, w_bh, w_bl;
  logic [S-1:0] w_sa, w_sb;
  logic [S-1:0] w_x, w_y;
  logic [P-1:0] w_p;
  logic [P-1:0] w_mid;

  assign w_ah = r_a[W-1:H];
  assign w_al = r_a[H-1:0];
  assign w_bh = r_b[W-1:H];
  assign w_bl = r_b[H-1:0];
  assign w_sa = {1'b0, w_ah} + {1'b0, w_al};
  assign w_sb = {1'b0, w_bh} + {1'b0, w_bl};

  // Operand select for the shared multiplier, one pairing per MUL state
  always_comb begin
    w_x = '0;
    w_y = '0;
    unique case (r_state)
      MUL_HI:  begin w_x = {1'b0, w_ah}; w_y = {1'b0, w_bh}; end
      MUL_LO:  begin w_x = {1'b0, w_al}; w_y = {1'b0, w_bl}; end
      MUL_MID: begin w_x = w_sa;         w_y = w_sb;         end
      default: ;
    endcase
  end

  kpp_mul #(.N(S)) u_mul (
    .i_x (w_x),
    .i_y (w_y),
    .o_p (w_p)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = MUL_HI;
      end
      MUL_HI:  w_next = MUL_LO;
      MUL_LO:  w_next = MUL_MID;
      MUL_MID: w_next = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture and partial-product registers; k regs only move in the
  // MUL states, so the terms derived from them are stable throughout OUT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_k1 <= '0;
      r_k2 <= '0;
      r_k3 <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (in_valid) begin
          r_a <= a;
          r_b <= b;
        end
        MUL_HI:  r_k1 <= w_p;
        MUL_LO:  r_k2 <= w_p;
        MUL_MID: r_k3 <= w_p;
        default: ;
      endcase
    end
  end

  // k3 >= k1 + k2 always holds, so the middle term never wraps
  assign w_mid = r_k3 - r_k2 - r_k1;

  assign g1 = {{(W-2){1'b0}}, r_k1} << W;
  assign g2 = {{(W-2){1'b0}}, w_mid} << H;
  assign g3 = {{(W-2){1'b0}}, r_k2};

endmodule

// File: tb/tb_karatsuba_pp_gen.sv
// Self-checking bench for karatsuba_pp_gen (W=32): directed corner vectors,
// backpressure, ignored input, mid-operation reset, random and throughput.
module tb_karatsuba_pp_gen;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           in_ready;
  logic           out_valid;
  logic [2*W-1:0] g1, g2, g3;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  karatsuba_pp_gen #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .g1        (g1),
    .g2        (g2),
    .g3        (g3)
  );

  // Reference: k1 from the high halves, k2 from the low halves, and the
  // middle term whatever is left of the exact full product.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [63:0] e1, output logic [63:0] e2,
                                output logic [63:0] e3, output logic [63:0] full);
    logic [63:0] xh, xl, yh, yl;
    xh = {48'b0, x[31:16]};
    xl = {48'b0, x[15:0]};
    yh = {48'b0, y[31:16]};
    yl = {48'b0, y[15:0]};
    full = {32'b0, x} * {32'b0, y};
    e1 = (xh * yh) << 32;
    e3 = xl * yl;
    e2 = full - e1 - e3;
  endfunction

  // Called just after a negedge with the DUT in IDLE; returns after the
  // accepting edge with in_valid dropped.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Cycles counted with the accepting cycle as cycle 0; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_ovalid_in_rst got %b want 0", out_valid); end
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vecs++;
    if (g1 !== 64'd0 || g2 !== 64'd0 || g3 !== 64'd0) begin
      errs++; $display("FAIL reset_terms got %h %h %h want zeros", g1, g2, g3);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic [63:0] t1 [3];
    logic [63:0] t2 [3];
    logic [63:0] t3 [3];
    int lat;
    ta[0] = 32'h00000003; tb[0] = 32'h00000005;
    t1[0] = 64'h0;        t2[0] = 64'h0;        t3[0] = 64'hF;
    ta[1] = 32'hFFFFFFFF; tb[1] = 32'hFFFFFFFF;
    t1[1] = 64'hFFFE000100000000; t2[1] = 64'h0001FFFC00020000; t3[1] = 64'h00000000FFFE0001;
    ta[2] = 32'h00010000; tb[2] = 32'h00010000;
    t1[2] = 64'h0000000100000000; t2[2] = 64'h0; t3[2] = 64'h0;
    out_ready = 1'b1;  // must be ignored until OUT
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb[i]);
      wait_valid(lat);
      vecs++;
      if (lat !== 4) begin errs++; $display("FAIL dir%0d_latency got %0d want 4", i, lat); end
      vecs++;
      if (g1 !== t1[i] || g2 !== t2[i] || g3 !== t3[i]) begin
        errs++; $display("FAIL dir%0d_terms got %h %h %h want %h %h %h", i, g1, g2, g3, t1[i], t2[i], t3[i]);
      end
      @(negedge clk);
    end
    vecs++;
    if (t1[1] + t2[1] + t3[1] !== 64'hFFFFFFFE00000001 || g1 + g2 + g3 !== 64'h0000000100000000) begin
      errs++; $display("FAIL dir_sum got %h want 0000000100000000", g1 + g2 + g3);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] x, y;
    logic [63:0] e1, e2, e3, f;
    int lat;
    bit bad;
    x = $urandom;
    y = $urandom;
    model(x, y, e1, e2, e3, f);
    out_ready = 1'b0;
    start_op(x, y);
    wait_valid(lat);
    vecs++;
    if (lat !== 4) begin errs++; $display("FAIL bp_latency got %0d want 4", lat); end
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || g1 !== e1 || g2 !== e2 || g3 !== e3) bad = 1'b1;
      @(negedge clk);
    end
    vecs++;
    if (bad) begin errs++; $display("FAIL bp_hold got valid=%b ready=%b %h %h %h want held %h %h %h", out_valid, in_ready, g1, g2, g3, e1, e2, e3); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vecs++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL bp_release got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_ignore_inputs();
    logic [31:0] x, y;
    logic [63:0] e1, e2, e3, f;
    x = $urandom;
    y = $urandom;
    model(x, y, e1, e2, e3, f);
    out_ready = 1'b0;
    start_op(x, y);
    @(negedge clk);            // MUL_HI
    @(negedge clk);            // MUL_LO
    vecs++;
    if (in_ready !== 1'b0) begin errs++; $display("FAIL ign_in_ready got %b want 0", in_ready); end
    a = ~x;
    b = ~y;
    in_valid = 1'b1;
    @(negedge clk);            // MUL_MID
    in_valid = 1'b0;
    @(negedge clk);            // OUT
    vecs++;
    if (out_valid !== 1'b1 || g1 !== e1 || g2 !== e2 || g3 !== e3) begin
      errs++; $display("FAIL ign_terms got v=%b %h %h %h want 1 %h %h %h", out_valid, g1, g2, g3, e1, e2, e3);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] x, y;
    logic [63:0] e1, e2, e3, f;
    int lat;
    bit seen;
    out_ready = 1'b1;
    start_op($urandom, $urandom);
    @(negedge clk);            // MUL_HI
    @(negedge clk);            // MUL_LO
    @(negedge clk);            // MUL_MID
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vecs++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || g1 !== 64'd0 || g2 !== 64'd0 || g3 !== 64'd0) begin
      errs++; $display("FAIL rstmid_state got rdy=%b v=%b %h %h %h want 1 0 zeros", in_ready, out_valid, g1, g2, g3);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    vecs++;
    if (seen) begin errs++; $display("FAIL rstmid_no_valid got pulse want none"); end
    x = $urandom;
    y = $urandom;
    model(x, y, e1, e2, e3, f);
    start_op(x, y);
    wait_valid(lat);
    vecs++;
    if (lat !== 4 || g1 !== e1 || g2 !== e2 || g3 !== e3) begin
      errs++; $display("FAIL rstmid_next got lat=%0d %h %h %h want 4 %h %h %h", lat, g1, g2, g3, e1, e2, e3);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic [63:0] e1, e2, e3, f;
    int lat, d;
    for (int i = 0; i < 20; i++) begin
      x = (i % 5 == 0) ? {$urandom_range(1, 0) ? 16'hFFFF : 16'h0000, 16'($urandom)} : $urandom;
      y = $urandom;
      model(x, y, e1, e2, e3, f);
      out_ready = 1'b0;
      start_op(x, y);
      wait_valid(lat);
      d = $urandom_range(3, 0);
      repeat (d) @(negedge clk);
      vecs++;
      if (lat !== 4 || out_valid !== 1'b1 || g1 !== e1 || g2 !== e2 || g3 !== e3) begin
        errs++; $display("FAIL rand%0d got lat=%0d v=%b %h %h %h want 4 1 %h %h %h", i, lat, out_valid, g1, g2, g3, e1, e2, e3);
      end
      vecs++;
      if (g1 + g2 + g3 !== f) begin errs++; $display("FAIL rand%0d_sum got %h want %h", i, g1 + g2 + g3, f); end
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc [$];
    logic [63:0] e1, e2, e3, f;
    bit bad;
    model(32'h12345678, 32'h9ABCDEF0, e1, e2, e3, f);
    a = 32'h12345678;
    b = 32'h9ABCDEF0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (in_ready) acc.push_back(c);
      if (out_valid && (g1 !== e1 || g2 !== e2 || g3 !== e3)) bad = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    vecs++;
    if (acc.size() < 3 || acc[1] - acc[0] != 5 || acc[2] - acc[1] != 5) begin
      errs++; $display("FAIL b2b_interval got %0d accepts want spacing 5", acc.size());
    end
    vecs++;
    if (bad) begin errs++; $display("FAIL b2b_terms got wrong terms want %h %h %h", e1, e2, e3); end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_ignore_inputs();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/karatsuba_pp_gen.md
KARATSUBA_PP_GEN -- requirements
Module: karatsuba_pp_gen

Interface
REQ-001 Parameter: W, default 32, operand width in bits; the value SHALL be even and at least 4.
REQ-002 Port: clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-003 Port: rst_n, input, 1 bit, reset; it SHALL be synchronous and active-low.
REQ-004 Port: in_valid, input, 1 bit, operand pair offered.
REQ-005 Port: in_ready, output, 1 bit, block can accept operands.
REQ-006 Port: a, input, W bits, multiplicand (unsigned).
REQ-007 Port: b, input, W bits, multiplier (unsigned).
REQ-008 Port: out_valid, output, 1 bit, g1/g2/g3 valid.
REQ-009 Port: out_ready, input, 1 bit, the downstream Kogge-Stone combine stage accepts the terms.
REQ-010 Port: g1, output, 2W bits, k1 shifted left by W.
REQ-011 Port: g2, output, 2W bits, (k3-k2-k1) shifted left by W/2.
REQ-012 Port: g3, output, 2W bits, k2 zero-extended.

Function
REQ-013 The operand split SHALL be H = bits [W-1:W/2] and L = bits [W/2-1:0] of each operand.
REQ-014 The partial products SHALL be k1 = aH*bH, k2 = aL*bL and k3 = (aH+aL)*(bH+bL).
REQ-015 Each sum in k3 SHALL be W/2+1 bits wide and each product W+2 bits wide; no truncation is allowed.
REQ-016 The middle term (k3-k2-k1) SHALL be computed unsigned in W+2 bits; it is never negative.
REQ-017 The sum g1+g2+g3 SHALL equal a*b exactly in 2W bits.
REQ-018 The FSM SHALL have the states IDLE, MUL_HI, MUL_LO, MUL_MID and OUT.
REQ-019 IDLE: in_ready=1; on in_valid&in_ready the block SHALL capture a and b, then go to MUL_HI.
REQ-020 MUL_HI SHALL register k1 and go to MUL_LO.
REQ-021 MUL_LO SHALL register k2 and go to MUL_MID.
REQ-022 MUL_MID SHALL register k3 and go to OUT.
REQ-023 Only one multiplier instance SHALL exist; it is time-shared across MUL_HI, MUL_LO and MUL_MID.
REQ-024 OUT: out_valid=1, and g1/g2/g3 SHALL be driven from registers and held stable until out_ready=1.
REQ-025 On out_valid&out_ready the block SHALL return to IDLE.
REQ-026 Latency: out_valid SHALL rise exactly 4 cycles after the accepting edge.
REQ-027 Minimum initiation interval SHALL be 5 cycles.
REQ-028 in_ready SHALL be 0 in every state except IDLE; in_valid in those states SHALL be ignored and SHALL NOT corrupt captured operands.
REQ-029 out_ready SHALL be ignored outside OUT.
REQ-030 out_valid SHALL NOT drop without a handshake.

Reset
REQ-031 When rst_n=0 at a clock edge, the state SHALL become IDLE, out_valid=0 and g1=g2=g3=0, and all k registers and captured operands SHALL be cleared.
REQ-032 In-flight work SHALL be discarded.
REQ-033 Reset asserted mid-operation, in any state, SHALL produce no out_valid pulse for the aborted operands.
REQ-034 in_ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-035 A shared package SHALL hold the FSM state enum (kpp_state_t) and the default width constant KPP_W=32.
REQ-036 One sub-module, kpp_mul (combinational unsigned (W/2+1)x(W/2+1) multiplier with a W+2-bit product), SHALL be instantiated once.
REQ-037 The shifts and the middle-term subtraction SHALL remain in karatsuba_pp_gen.

Verification
REQ-038 a=0x00000003, b=0x00000005 -> g1=0, g2=0, g3=0xF; out_valid 4 cycles after accept.
REQ-039 a=b=0xFFFFFFFF -> g1=0xFFFE000100000000, g2=0x0001FFFC00020000, g3=0x00000000FFFE0001; sum=0xFFFFFFFE00000001.
REQ-040 a=0x00010000, b=0x00010000 -> g1=0x0000000100000000, g2=0, g3=0.
REQ-041 Hold out_ready=0 for 6 cycles in OUT -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-042 Drive in_valid with new operands during MUL_LO -> ignored; results match the first pair.
REQ-043 rst_n=0 for 1 cycle in MUL_MID -> no out_valid; IDLE with zeroed outputs; the next operation is correct.
